dct_cos_rom: RTL and testbench

- Q1.15 cosine coefficient ROM for the DCT engine.
- Provides entries cos(pi*i/MAX_SIZE) for i = 0..MAX_SIZE, both as a registered parallel table bus and through a 1-cycle random-access lookup port.
- The lookup port covers the full period 0..2*MAX_SIZE-1 by mirroring.
- Sits beside the DCT datapath; the datapath multiplies samples by these terms.

---
 rtl/dct_cos_rom.sv | 153 +++++++++++++++
 tb/tb_dct_cos_rom.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_cos_rom.sv
`default_nettype none
// ============================================================================
// Module   : dct_cos_rom
// Purpose  : Q1.15 cosine coefficient ROM for the DCT engine. Holds a
//            33-entry quarter-wave table of cos(pi*j/64) and expands it to
//            the half wave cos(pi*i/MAX_SIZE), i = 0..MAX_SIZE.
//            After reset the table register is filled one entry per clock
//            and exposed as a parallel bus. A 1-cycle random-access
//            lookup port covers the full period 0..2*MAX_SIZE-1 by
//            mirroring.
// Ports    : clk         - rising-edge clock
//            reset_n     - asynchronous active-low reset
//            table_q15   - (MAX_SIZE+1)*NBITS parallel table, entry i at
//                          [i*NBITS +: NBITS], signed Q1.15
//            table_valid - high once all MAX_SIZE+1 entries are loaded
//            rd_en       - lookup request
//            rd_idx      - lookup index, 0..2*MAX_SIZE-1
//            rd_data     - signed Q1.15 lookup result
//            rd_valid    - rd_data is valid this cycle
// Revision : 1.0 - initial release
// ============================================================================
module dct_cos_rom #(
  parameter int MAX_SIZE = 64,
  parameter int NBITS    = 16,
  parameter int IDXW     = $clog2(2*MAX_SIZE)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  output logic [(MAX_SIZE+1)*NBITS-1:0]  table_q15,
  output logic                           table_valid,
  input  logic                           rd_en,
  input  logic [IDXW-1:0]                rd_idx,
  output logic [NBITS-1:0]               rd_data,
  output logic                           rd_valid
);

  // Quarter-wave step multiplier: table index i maps to quarter index i*STEP.
  localparam int C_STEP = 64 / MAX_SIZE;

  // round(cos(pi*j/64)*32768), j = 0..32, with j=0 saturated to 32767.
  function automatic logic [15:0] f_quarter(input logic [5:0] j);
    case (j)
      6'd0:  f_quarter = 16'd32767;
      6'd1:  f_quarter = 16'd32729;
      6'd2:  f_quarter = 16'd32610;
      6'd3:  f_quarter = 16'd32413;
      6'd4:  f_quarter = 16'd32138;
      6'd5:  f_quarter = 16'd31786;
      6'd6:  f_quarter = 16'd31357;
      6'd7:  f_quarter = 16'd30853;
      6'd8:  f_quarter = 16'd30274;
      6'd9:  f_quarter = 16'd29622;
      6'd10: f_quarter = 16'd28899;
      6'd11: f_quarter = 16'd28106;
      6'd12: f_quarter = 16'd27246;
      6'd13: f_quarter = 16'd26320;
      6'd14: f_quarter = 16'd25330;
      6'd15: f_quarter = 16'd24279;
      6'd16: f_quarter = 16'd23170;
      6'd17: f_quarter = 16'd22006;
      6'd18: f_quarter = 16'd20788;
      6'd19: f_quarter = 16'd19520;
      6'd20: f_quarter = 16'd18205;
      6'd21: f_quarter = 16'd16846;
      6'd22: f_quarter = 16'd15447;
      6'd23: f_quarter = 16'd14010;
      6'd24: f_quarter = 16'd12540;
      6'd25: f_quarter = 16'd11039;
      6'd26: f_quarter = 16'd9512;
      6'd27: f_quarter = 16'd7962;
      6'd28: f_quarter = 16'd6393;
      6'd29: f_quarter = 16'd4808;
      6'd30: f_quarter = 16'd3212;
      6'd31: f_quarter = 16'd1608;
      default: f_quarter = 16'd0;
    endcase
  endfunction

  // Half-wave entry: second quarter is the negated mirror of the first.
  function automatic logic [NBITS-1:0] f_half(input logic [IDXW-1:0] i);
    logic [6:0] u;
    u = 7'(i) * 7'(C_STEP);
    if (u <= 7'd32)
      f_half = f_quarter(6'(u));
    else
      f_half = -f_quarter(6'(7'd64 - u));
  endfunction

  // Fold a full-period index onto the half wave (k > MAX_SIZE -> 2*MAX_SIZE-k).
  // The index width already wraps modulo 2*MAX_SIZE.
  function automatic logic [IDXW-1:0] f_fold(input logic [IDXW-1:0] k);
    if (k <= IDXW'(MAX_SIZE))
      f_fold = k;
    else
      f_fold = IDXW'((IDXW+1)'(2*MAX_SIZE) - (IDXW+1)'(k));
  endfunction

  logic [NBITS-1:0] r_table [0:MAX_SIZE];
  logic [IDXW-1:0]  r_cnt;
  logic             r_table_valid;
  logic [NBITS-1:0] r_rd_data;
  logic             r_rd_valid;
  logic [IDXW-1:0]  w_fold_idx;

  // --------------------------------------------------------------------------
  // Table fill: one entry per clock; the counter parks on the last entry and
  // table_valid freezes the table until the next reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= MAX_SIZE; i++) r_table[i] <= '0;
      r_cnt         <= '0;
      r_table_valid <= 1'b0;
    end else if (!r_table_valid) begin
      for (int i = 0; i <= MAX_SIZE; i++) begin
        if (r_cnt == IDXW'(i)) r_table[i] <= f_half(IDXW'(i));
      end
      if (r_cnt == IDXW'(MAX_SIZE))
        r_table_valid <= 1'b1;
      else
        r_cnt <= r_cnt + IDXW'(1);
    end
  end

  generate
    for (genvar gi = 0; gi <= MAX_SIZE; gi++) begin : g_pack
      assign table_q15[gi*NBITS +: NBITS] = r_table[gi];
    end
  endgenerate

  assign table_valid = r_table_valid;

  // --------------------------------------------------------------------------
  // Lookup: reads the constant ROM directly, so it is independent of the fill.
  // rd_data holds its last value when no request is made.
  // --------------------------------------------------------------------------
  assign w_fold_idx = f_fold(rd_idx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= f_half(w_fold_idx);
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_dct_cos_rom.sv
`default_nettype none
// ============================================================================
// Module   : tb_dct_cos_rom
// Purpose  : Self-checking bench for dct_cos_rom, MAX_SIZE=64 and MAX_SIZE=8
//            instances. Expected values come from constant vector tables and
//            from a cosine reference model built on $cos.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dct_cos_rom;

  logic clk;
  logic reset_n;

  // MAX_SIZE = 64 instance
  logic [65*16-1:0] tbl64;
  logic             tv64;
  logic             rd_en64;
  logic [6:0]       rd_idx64;
  logic [15:0]      rd_data64;
  logic             rd_valid64;

  // MAX_SIZE = 8 instance
  logic [9*16-1:0]  tbl8;
  logic             tv8;
  logic             rd_en8;
  logic [3:0]       rd_idx8;
  logic [15:0]      rd_data8;
  logic             rd_valid8;

  int checks = 0;
  int errors = 0;

  dct_cos_rom #(.MAX_SIZE(64)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .table_q15(tbl64), .table_valid(tv64),
    .rd_en(rd_en64), .rd_idx(rd_idx64), .rd_data(rd_data64), .rd_valid(rd_valid64)
  );

  dct_cos_rom #(.MAX_SIZE(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .table_q15(tbl8), .table_valid(tv8),
    .rd_en(rd_en8), .rd_idx(rd_idx8), .rd_data(rd_data8), .rd_valid(rd_valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int exp;
  } vec_t;

  // ---------------- reference model ----------------
  function automatic int ref_q(input int j);
    real r;
    int  v;
    r = $cos(3.14159265358979323846 * j / 64.0) * 32768.0;
    v = $rtoi(r + 0.5);
    if (v > 32767) v = 32767;
    return v;
  endfunction

  function automatic int ref_half(input int i, input int ms);
    int u;
    u = i * (64 / ms);
    if (u <= 32) return ref_q(u);
    return -ref_q(64 - u);
  endfunction

  function automatic int ref_full(input int k, input int ms);
    int m;
    m = k % (2 * ms);
    if (m <= ms) return ref_half(m, ms);
    return ref_half(2 * ms - m, ms);
  endfunction

  function automatic int ent64(input int i);
    logic [15:0] v;
    v = tbl64[i*16 +: 16];
    return int'($signed(v));
  endfunction

  function automatic int ent8(input int i);
    logic [15:0] v;
    v = tbl8[i*16 +: 16];
    return int'($signed(v));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for both tables to finish filling; returns edge counts since release.
  task automatic wait_fill(input bit random_lookups, output int n64, output int n8);
    bit en;
    int idx;
    int idx8;
    bit en8;
    int exp_v64, exp_d64, exp_v8, exp_d8;
    exp_v64 = 0; exp_d64 = 0; exp_v8 = 0; exp_d8 = 0;
    n64 = 0;
    n8  = -1;
    while (!tv64 && n64 < 200) begin
      en   = 1'b0;
      en8  = 1'b0;
      idx  = 0;
      idx8 = 0;
      if (random_lookups) begin
        en   = 1'($urandom_range(0, 1));
        idx  = $urandom_range(0, 127);
        en8  = 1'($urandom_range(0, 1));
        idx8 = $urandom_range(0, 15);
      end
      rd_en64  = en;
      rd_idx64 = 7'(idx);
      rd_en8   = en8;
      rd_idx8  = 4'(idx8);
      tick();
      n64++;
      if (tv8 && n8 < 0) n8 = n64;
      if (n64 == 10) begin
        chk("fill_partial_e9", ent64(9), ref_half(9, 64));
        chk("fill_unwritten_e10", ent64(10), 0);
      end
      if (random_lookups) begin
        if (en) begin exp_v64 = 1; exp_d64 = ref_full(idx, 64); end
        else exp_v64 = 0;
        if (en8) begin exp_v8 = 1; exp_d8 = ref_full(idx8, 8); end
        else exp_v8 = 0;
        chk("rand64_valid", int'(rd_valid64), exp_v64);
        chk("rand64_data", int'($signed(rd_data64)), exp_d64);
        chk("rand8_valid", int'(rd_valid8), exp_v8);
        chk("rand8_data", int'($signed(rd_data8)), exp_d8);
      end
    end
    rd_en64 = 1'b0;
    rd_en8  = 1'b0;
  endtask

  initial begin
    vec_t tab64 [8];
    vec_t lk64  [6];
    vec_t tab8  [9];
    vec_t lk8   [5];
    int n64, n8;

    tab64[0] = '{0, 32767};  tab64[1] = '{1, 32729};  tab64[2] = '{8, 30274};
    tab64[3] = '{16, 23170}; tab64[4] = '{24, 12540}; tab64[5] = '{32, 0};
    tab64[6] = '{48, -23170}; tab64[7] = '{64, -32767};

    lk64[0] = '{0, 32767};  lk64[1] = '{64, -32767}; lk64[2] = '{65, -32729};
    lk64[3] = '{96, 0};     lk64[4] = '{127, 32729}; lk64[5] = '{33, -1608};

    tab8[0] = '{0, 32767};  tab8[1] = '{1, 30274};  tab8[2] = '{2, 23170};
    tab8[3] = '{3, 12540};  tab8[4] = '{4, 0};      tab8[5] = '{5, -12540};
    tab8[6] = '{6, -23170}; tab8[7] = '{7, -30274}; tab8[8] = '{8, -32767};

    lk8[0] = '{12, 0}; lk8[1] = '{15, 30274}; lk8[2] = '{8, -32767};
    lk8[3] = '{0, 32767}; lk8[4] = '{10, -23170};

    reset_n  = 1'b1;
    rd_en64  = 1'b0;
    rd_idx64 = '0;
    rd_en8   = 1'b0;
    rd_idx8  = '0;

    // ---------------- reset ----------------
    #2 reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_table64_zero", int'(tbl64 == '0), 1);
    chk("rst_valid64", int'(tv64), 0);
    chk("rst_rd_valid64", int'(rd_valid64), 0);
    chk("rst_rd_data64", int'(rd_data64), 0);
    chk("rst_table8_zero", int'(tbl8 == '0), 1);
    chk("rst_valid8", int'(tv8), 0);

    // ---------------- fill ----------------
    reset_n = 1'b1;
    wait_fill(1'b0, n64, n8);
    chk("fill_latency64", n64, 65);
    chk("fill_latency8", n8, 9);

    for (int v = 0; v < 8; v++)
      chk($sformatf("tab64_e%0d", tab64[v].idx), ent64(tab64[v].idx), tab64[v].exp);
    for (int v = 0; v < 9; v++)
      chk($sformatf("tab8_e%0d", tab8[v].idx), ent8(tab8[v].idx), tab8[v].exp);
    for (int i = 0; i <= 64; i++)
      chk($sformatf("model64_e%0d", i), ent64(i), ref_half(i, 64));

    // valid stays high
    repeat (3) tick();
    chk("valid64_sticky", int'(tv64), 1);

    // ---------------- single lookups ----------------
    for (int v = 0; v < 6; v++) begin
      rd_en64  = 1'b1;
      rd_idx64 = 7'(lk64[v].idx);
      tick();
      rd_en64 = 1'b0;
      chk($sformatf("lk64_valid_%0d", lk64[v].idx), int'(rd_valid64), 1);
      chk($sformatf("lk64_data_%0d", lk64[v].idx), int'($signed(rd_data64)), lk64[v].exp);
      tick();
      chk($sformatf("lk64_drop_%0d", lk64[v].idx), int'(rd_valid64), 0);
      chk($sformatf("lk64_hold_%0d", lk64[v].idx), int'($signed(rd_data64)), lk64[v].exp);
    end
    for (int v = 0; v < 5; v++) begin
      rd_en8  = 1'b1;
      rd_idx8 = 4'(lk8[v].idx);
      tick();
      rd_en8 = 1'b0;
      chk($sformatf("lk8_valid_%0d", lk8[v].idx), int'(rd_valid8), 1);
      chk($sformatf("lk8_data_%0d", lk8[v].idx), int'($signed(rd_data8)), lk8[v].exp);
    end

    // ---------------- back-to-back ----------------
    rd_en64 = 1'b1; rd_idx64 = 7'd16;
    tick();
    chk("b2b_v0", int'(rd_valid64), 1);
    chk("b2b_d0", int'($signed(rd_data64)), 23170);
    rd_idx64 = 7'd112;
    tick();
    chk("b2b_v1", int'(rd_valid64), 1);
    chk("b2b_d1", int'($signed(rd_data64)), 23170);
    rd_idx64 = 7'd32;
    tick();
    chk("b2b_v2", int'(rd_valid64), 1);
    chk("b2b_d2", int'($signed(rd_data64)), 0);
    rd_en64 = 1'b0;
    tick();
    chk("b2b_drop", int'(rd_valid64), 0);
    chk("b2b_hold", int'($signed(rd_data64)), 0);

    // ---------------- mid-fill reset ----------------
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (20) tick();
    chk("midfill_e19_loaded", ent64(19), ref_half(19, 64));
    #2 reset_n = 1'b0;
    #1;
    chk("async_clear_table64", int'(tbl64 == '0), 1);
    chk("async_clear_valid64", int'(tv64), 0);
    chk("async_clear_table8", int'(tbl8 == '0), 1);
    chk("async_clear_valid8", int'(tv8), 0);
    tick();
    tick();
    chk("held_reset_table64", int'(tbl64 == '0), 1);
    reset_n = 1'b1;
    // refill with concurrent random lookups
    wait_fill(1'b1, n64, n8);
    chk("refill_latency64", n64, 65);
    chk("refill_latency8", n8, 9);
    for (int i = 0; i <= 64; i++)
      chk($sformatf("refill64_e%0d", i), ent64(i), ref_half(i, 64));
    for (int i = 0; i <= 8; i++)
      chk($sformatf("refill8_e%0d", i), ent8(i), ref_half(i, 8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
